// File: rtl/mul_pkg.sv
// Shared encodings and helpers for the sequenced RV32M multiply controller.
package mul_pkg;

  typedef logic [1:0] mul_op_t;
  typedef logic [1:0] mul_state_t;

  localparam mul_op_t MUL_OP_MUL    = 2'b00;
  localparam mul_op_t MUL_OP_MULH   = 2'b01;
  localparam mul_op_t MUL_OP_MULHSU = 2'b10;
  localparam mul_op_t MUL_OP_MULHU  = 2'b11;

  localparam mul_state_t S_IDLE = 2'b00;
  localparam mul_state_t S_BUSY = 2'b01;
  localparam mul_state_t S_DONE = 2'b10;

  localparam int CNT_W = 3;

  function automatic logic [63:0] neg64_cond(input logic [63:0] v, input logic neg);
    logic [63:0] r;
    if (neg) begin
      r = ~v + 64'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [31:0] sel_result(input mul_op_t op, input logic [63:0] p);
    logic [31:0] r;
    if (op == MUL_OP_MUL) begin
      r = p[31:0];
    end else begin
      r = p[63:32];
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle sequencer around an external 32x32 multiplier: latches operands,
// holds them for MUL_CYCLES, then captures and returns the selected result half.
import mul_pkg::*;

module mul_seq_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [31:0]      mul_src1,
  output logic [31:0]      mul_src2,
  output logic             mul_sign,
  input  logic [63:0]      mul_result
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  mul_op_t          r_op;
  logic             r_neg;
  logic [31:0]      r_src1;
  logic [31:0]      r_src2;
  logic             r_sign;
  logic [31:0]      r_data;
  logic [TAG_W-1:0] r_tag;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_src1_neg;
  logic [31:0]      w_src1_mag;
  logic             w_sign;
  logic [63:0]      w_product;

  // Request acceptance: IDLE, or DONE while the result is being consumed; flush blocks it.
  always_comb begin
    w_req_ready = 1'b0;
    if (flush) begin
      w_req_ready = 1'b0;
    end else if (r_state == S_IDLE) begin
      w_req_ready = 1'b1;
    end else if (r_state == S_DONE) begin
      w_req_ready = resp_ready;
    end else begin
      w_req_ready = 1'b0;
    end
  end

  assign w_accept = w_req_ready & req_valid;

  // MULHSU feeds |src1| to an unsigned multiply; the sign is restored on capture.
  always_comb begin
    w_src1_neg = (req_op == MUL_OP_MULHSU) & req_src1[31];
    w_sign     = (req_op == MUL_OP_MUL) | (req_op == MUL_OP_MULH);
    if (w_src1_neg) begin
      w_src1_mag = ~req_src1 + 32'd1;
    end else begin
      w_src1_mag = req_src1;
    end
  end

  assign w_product = neg64_cond(mul_result, r_neg);

  // Control FSM and multicycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else if (w_accept) begin
      r_state <= S_BUSY;
      r_cnt   <= CNT_LOAD;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_BUSY: begin
          if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Operand/tag latch on accept; the multiplier inputs hold their last value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= MUL_OP_MUL;
      r_neg  <= 1'b0;
      r_src1 <= 32'd0;
      r_src2 <= 32'd0;
      r_sign <= 1'b0;
      r_tag  <= {TAG_W{1'b0}};
    end else if (w_accept) begin
      r_op   <= req_op;
      r_neg  <= w_src1_neg;
      r_src1 <= w_src1_mag;
      r_src2 <= req_src2;
      r_sign <= w_sign;
      r_tag  <= req_tag;
    end
  end

  // Result capture at the end of the BUSY window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 32'd0;
    end else if (!flush && (r_state == S_BUSY) && (r_cnt == CNT_ZERO)) begin
      r_data <= sel_result(r_op, w_product);
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = (r_state == S_DONE);
  assign busy       = (r_state == S_BUSY) | (r_state == S_DONE);
  assign resp_data  = r_data;
  assign resp_tag   = r_tag;
  assign mul_src1   = r_src1;
  assign mul_src2   = r_src2;
  assign mul_sign   = r_sign;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a behavioural multiplier and RV32M reference.
module tb_mul_seq_ctrl;

  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, resp_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic [4:0]  req_tag;
  logic        req_ready, resp_valid, busy, mul_sign;
  logic [31:0] resp_data, mul_src1, mul_src2;
  logic [4:0]  resp_tag;
  logic [63:0] mul_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.MUL_CYCLES(MC), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_sign(mul_sign),
    .mul_result(mul_result)
  );

  // External multiplier: signed x signed when mul_sign, else unsigned x unsigned.
  always_comb begin
    if (mul_sign) mul_result = 64'(longint'($signed(mul_src1)) * longint'($signed(mul_src2)));
    else          mul_result = {32'd0, mul_src1} * {32'd0, mul_src2};
  end

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = 64'(sa * sb);
      2'b10: p = 64'(sa * ub);
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
  endtask

  task automatic wait_resp(input string name, output int k);
    k = 0;
    while (resp_valid !== 1'b1 && k < 20) begin tick(); k++; end
    n_cmp++;
    if (k != MC) begin n_bad++; $display("FAIL %s latency: got %0d cycles, want %0d", name, k, MC); end
  endtask

  task automatic send_and_check(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] tag, input int hold, input string name);
    logic [31:0] exp, exp_mag;
    logic        exp_sign;
    int          k;
    exp      = ref_result(op, a, b);
    exp_mag  = (op == 2'b10 && a[31]) ? (32'd0 - a) : a;
    exp_sign = (op == 2'b00 || op == 2'b01);
    drive_req(op, a, b, tag); #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL %s req_ready idle: got %b want 1", name, req_ready); end
    tick(); req_valid = 1'b0; #1;
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL %s busy window: busy=%b req_ready=%b want 1/0", name, busy, req_ready);
    end
    n_cmp++;
    if (mul_src1 !== exp_mag || mul_src2 !== b || mul_sign !== exp_sign) begin
      n_bad++; $display("FAIL %s operands: got %h %h %b want %h %h %b", name, mul_src1, mul_src2, mul_sign, exp_mag, b, exp_sign);
    end
    wait_resp(name, k);
    for (int i = 0; i <= hold; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== exp || resp_tag !== tag) begin
        n_bad++; $display("FAIL %s resp: valid=%b data=%h tag=%0d want 1 %h %0d", name, resp_valid, resp_data, resp_tag, exp, tag);
      end
      if (i < hold) tick();
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s after handshake: valid=%b busy=%b want 0 0", name, resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req_op = 2'b00; req_src1 = 32'd0; req_src2 = 32'd0; req_tag = 5'd0;
    #3;
    n_cmp++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'd0 || resp_tag !== 5'd0 ||
        mul_src1 !== 32'd0 || mul_src2 !== 32'd0 || mul_sign !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset: valid=%b busy=%b data=%h tag=%0d src=%h/%h sign=%b rdy=%b",
                        resp_valid, busy, resp_data, resp_tag, mul_src1, mul_src2, mul_sign, req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    send_and_check(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd9, 0, "mul_neg");
    send_and_check(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 0, "mulh_min");
    send_and_check(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 0, "mulhu_max");
    send_and_check(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, "mulhsu_m1");
    send_and_check(2'b10, 32'h8000_0000, 32'd2, 5'd30, 0, "mulhsu_min");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp2;
    int          k;
    exp2 = ref_result(2'b01, 32'h1234_5678, 32'hF000_0001);
    drive_req(2'b00, 32'd1000, 32'd3000, 5'd5);
    tick(); req_valid = 1'b0;
    wait_resp("b2b_first", k);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== 32'd3_000_000 || resp_tag !== 5'd5) begin
        n_bad++; $display("FAIL b2b_hold: valid=%b data=%h tag=%0d want 1 %h 5", resp_valid, resp_data, resp_tag, 32'd3_000_000);
      end
      tick();
    end
    resp_ready = 1'b1; drive_req(2'b01, 32'h1234_5678, 32'hF000_0001, 5'd22); #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    tick(); resp_ready = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_no_bubble: busy=%b valid=%b want 1 0", busy, resp_valid);
    end
    wait_resp("b2b_second", k);
    n_cmp++;
    if (resp_data !== exp2 || resp_tag !== 5'd22) begin
      n_bad++; $display("FAIL b2b_second_data: got %h/%0d want %h/22", resp_data, resp_tag, exp2);
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    int k;
    drive_req(2'b11, 32'd5, 32'd6, 5'd4);
    tick(); req_valid = 1'b0; flush = 1'b1; #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_busy_ready: got %b want 0", req_ready); end
    tick(); flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_busy: busy=%b valid=%b want 0 0", busy, resp_valid); end
    repeat (MC + 2) tick();
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_busy_late: valid=%b want 0", resp_valid); end

    drive_req(2'b00, 32'd2, 32'd3, 5'd8);
    tick(); req_valid = 1'b0;
    wait_resp("flush_done_pre", k);
    flush = 1'b1; resp_ready = 1'b1; drive_req(2'b00, 32'd4, 32'd4, 5'd12); #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_done_ready: got %b want 0", req_ready); end
    tick(); flush = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_done: busy=%b valid=%b want 0 0", busy, resp_valid); end

    flush = 1'b1; drive_req(2'b01, 32'd9, 32'd9, 5'd13); #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_idle_ready: got %b want 0", req_ready); end
    tick(); flush = 1'b0; req_valid = 1'b0;
    repeat (MC + 1) tick();
    n_cmp++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_idle_latched: busy=%b valid=%b want 0 0", busy, resp_valid); end
  endtask

  task automatic test_async_reset();
    drive_req(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd27);
    tick(); req_valid = 1'b0;
    #2; rst = 1'b1; #1;
    n_cmp++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || mul_src1 !== 32'd0 || mul_src2 !== 32'd0 ||
        mul_sign !== 1'b0 || resp_tag !== 5'd0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL async_reset: busy=%b valid=%b src=%h/%h sign=%b tag=%0d rdy=%b",
                        busy, resp_valid, mul_src1, mul_src2, mul_sign, resp_tag, req_ready);
    end
    @(negedge clk); rst = 1'b0;
    tick();
    send_and_check(2'b00, 32'h0001_0003, 32'h0000_0101, 5'd11, 1, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] corners [6];
    logic [31:0] a, b;
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF; corners[5] = 32'hFFFF_FFFE;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      send_and_check(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)),
                     int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

endmodule
